// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: registers fetched words for decode, joins a prefixed
// opcode word with the immediate word that follows it, obeys stall/flush from
// the hazard unit and keeps a saturating count of inserted bubbles.
module if_id_stage #(
  parameter int                INST_W  = 16,
  parameter int                PC_W    = 32,
  parameter int                PFX_HI  = 15,
  parameter logic [1:0]        PFX_VAL = 2'b11,
  parameter logic [INST_W-1:0] NOP     = {INST_W{1'b0}}
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_fetch_valid,
  input  logic [INST_W-1:0] i_fetch_inst,
  input  logic [PC_W-1:0]   i_fetch_pc,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_id_valid,
  output logic [INST_W-1:0] o_id_inst,
  output logic [INST_W-1:0] o_id_imm,
  output logic [PC_W-1:0]   o_id_pc,
  output logic              o_id_two_word,
  output logic              o_imm_pending,
  output logic [15:0]       o_bubble_cnt
);

  typedef enum logic {S_NORM = 1'b0, S_IMM = 1'b1} state_t;

  state_t              r_state,       w_state_next;
  logic [INST_W-1:0]   r_hold_inst,   w_hold_inst_next;
  logic [PC_W-1:0]     r_hold_pc,     w_hold_pc_next;
  logic                r_id_valid,    w_id_valid_next;
  logic [INST_W-1:0]   r_id_inst,     w_id_inst_next;
  logic [INST_W-1:0]   r_id_imm,      w_id_imm_next;
  logic [PC_W-1:0]     r_id_pc,       w_id_pc_next;
  logic                r_id_two_word, w_id_two_word_next;
  logic                r_imm_pending;
  logic [15:0]         r_bubble_cnt,  w_bubble_cnt_next;
  logic                w_bubble;
  logic [1:0]          w_prefix;

  assign w_prefix = i_fetch_inst[PFX_HI -: 2];

  // Saturating bubble counter: never wraps past all-ones.
  assign w_bubble_cnt_next = (w_bubble && (r_bubble_cnt != 16'hFFFF))
                             ? r_bubble_cnt + 16'd1 : r_bubble_cnt;

  // Next-state and next-output selection; flush beats stall, stall freezes everything.
  always_comb begin
    w_state_next       = r_state;
    w_hold_inst_next   = r_hold_inst;
    w_hold_pc_next     = r_hold_pc;
    w_id_valid_next    = r_id_valid;
    w_id_inst_next     = r_id_inst;
    w_id_imm_next      = r_id_imm;
    w_id_pc_next       = r_id_pc;
    w_id_two_word_next = r_id_two_word;
    w_bubble           = 1'b0;
    if (i_flush) begin
      // Any half-assembled instruction is dropped by returning to S_NORM.
      w_id_valid_next    = 1'b0;
      w_id_inst_next     = NOP;
      w_id_imm_next      = {INST_W{1'b0}};
      w_id_two_word_next = 1'b0;
      w_state_next       = S_NORM;
      w_bubble           = 1'b1;
    end else if (!i_stall) begin
      case (r_state)
        S_NORM: begin
          if (i_fetch_valid && (w_prefix != PFX_VAL)) begin
            w_id_valid_next    = 1'b1;
            w_id_inst_next     = i_fetch_inst;
            w_id_imm_next      = {INST_W{1'b0}};
            w_id_pc_next       = i_fetch_pc;
            w_id_two_word_next = 1'b0;
          end else if (i_fetch_valid) begin
            // Opcode of a two-word instruction: park it until the immediate arrives.
            w_hold_inst_next = i_fetch_inst;
            w_hold_pc_next   = i_fetch_pc;
            w_id_valid_next  = 1'b0;
            w_id_inst_next   = NOP;
            w_state_next     = S_IMM;
            w_bubble         = 1'b1;
          end else begin
            w_id_valid_next = 1'b0;
            w_id_inst_next  = NOP;
            w_bubble        = 1'b1;
          end
        end
        S_IMM: begin
          if (i_fetch_valid) begin
            // Whatever arrives now is the immediate; its prefix bits are not examined.
            w_id_valid_next    = 1'b1;
            w_id_inst_next     = r_hold_inst;
            w_id_imm_next      = i_fetch_inst;
            w_id_pc_next       = r_hold_pc;
            w_id_two_word_next = 1'b1;
            w_state_next       = S_NORM;
          end else begin
            w_id_valid_next = 1'b0;
            w_bubble        = 1'b1;
          end
        end
        default: w_state_next = S_NORM;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_NORM;
      r_hold_inst   <= {INST_W{1'b0}};
      r_hold_pc     <= {PC_W{1'b0}};
      r_id_valid    <= 1'b0;
      r_id_inst     <= NOP;
      r_id_imm      <= {INST_W{1'b0}};
      r_id_pc       <= {PC_W{1'b0}};
      r_id_two_word <= 1'b0;
      r_imm_pending <= 1'b0;
      r_bubble_cnt  <= 16'd0;
    end else begin
      r_state       <= w_state_next;
      r_hold_inst   <= w_hold_inst_next;
      r_hold_pc     <= w_hold_pc_next;
      r_id_valid    <= w_id_valid_next;
      r_id_inst     <= w_id_inst_next;
      r_id_imm      <= w_id_imm_next;
      r_id_pc       <= w_id_pc_next;
      r_id_two_word <= w_id_two_word_next;
      r_imm_pending <= (w_state_next == S_IMM);
      r_bubble_cnt  <= w_bubble_cnt_next;
    end
  end

  assign o_id_valid    = r_id_valid;
  assign o_id_inst     = r_id_inst;
  assign o_id_imm      = r_id_imm;
  assign o_id_pc       = r_id_pc;
  assign o_id_two_word = r_id_two_word;
  assign o_imm_pending = r_imm_pending;
  assign o_bubble_cnt  = r_bubble_cnt;

endmodule
